// File: rtl/mux_scan_sequencer_pkg.sv
// Shared types and widths for the mux scan sequencer and its select counter.
package mux_scan_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int IDX_W = 3;
  localparam int CNT_W = 4;

endpackage

// File: rtl/mux_scan_sequencer_sel_counter.sv
// Select index / dwell counter: holds each index DWELL enabled cycles, stops at the last index.
module sel_counter_3b
  import mux_scan_sequencer_pkg::*;
#(
  parameter int DWELL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [IDX_W-1:0] idx,
  output logic             tc
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = '1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      cnt <= '0;
    end else if (clr) begin
      idx <= '0;
      cnt <= '0;
    end else if (en) begin
      if (cnt == DWELL_LAST) begin
        cnt <= '0;
        // the last index is never wrapped; it parks until the next clear
        if (idx != IDX_LAST) idx <= idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign tc = (cnt == DWELL_LAST) && (idx == IDX_LAST);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scans a captured byte through a downstream 8:1 mux by stepping its select code.
// Optional MUX_SCAN_HOLD_EN adds a hold input that freezes the scan while asserted.
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int DWELL = 1
) (
  input  logic       clk,
  input  logic       rst,
`ifdef MUX_SCAN_HOLD_EN
  input  logic       hold,
`endif
  input  logic       load,
  input  logic [7:0] din,
  output logic       ready,
  output logic [7:0] I,
  output logic       S2,
  output logic       S1,
  output logic       S0,
  output logic       sel_valid,
  output logic       done
);
  // state | meaning
  // IDLE  | waiting for load, word and last select held
  // SCAN  | stepping select 000..111, DWELL cycles each
  // DONE  | one-cycle completion pulse

  state_t state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic tc, cnt_en, cnt_clr, scan_hold, accept;

`ifdef MUX_SCAN_HOLD_EN
  assign scan_hold = hold;
`else
  assign scan_hold = 1'b0;
`endif

  assign accept  = (state == IDLE) && load;
  assign cnt_en  = (state == SCAN) && !scan_hold;
  assign cnt_clr = accept;

  sel_counter_3b #(.DWELL(DWELL)) u_sel_counter (
    .clk (clk),
    .rst (rst),
    .en  (cnt_en),
    .clr (cnt_clr),
    .idx (idx),
    .tc  (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SCAN;
      SCAN:    if (cnt_en && tc) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    sel_valid = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    ready     = 1'b1;
      SCAN:    sel_valid = 1'b1;
      DONE:    done      = 1'b1;
      default: ready     = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         I <= 8'h00;
    else if (accept) I <= din;
  end

  assign {S2, S1, S0} = idx;

endmodule
